fpa_sched: RTL and testbench

FPA_SCHED -- requirements
Module: fpa_sched

---
 rtl/fpa_sched.sv | 167 ++++++++++++++++
 tb/tb_fpa_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpa_sched.sv
// Two-requester scheduler in front of a pipelined single-precision FP core.
// Round-robin issue, tag pipeline tracking which requester owns each in-flight
// operation, and a small result FIFO per requester sized to its credit limit.
module fpa_sched #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_data,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_data,
    output logic [31:0] fpa_a,
    output logic [31:0] fpa_b,
    input  logic [31:0] fpa_out,
    output logic        busy
);

    localparam logic [2:0] DepthC  = 3'(DEPTH);
    localparam logic [1:0] LastPtr = 2'(DEPTH - 1);

    logic [1:0]  req_valid, elig, grant, res_ready, res_valid, pop, push_n;
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic        acc, acc_id, push, push_id;

    logic        rr_q, rr_d;
    logic [31:0] fpa_a_q, fpa_a_d, fpa_b_q, fpa_b_d;
    // One stage beyond LAT accounts for the operand register in front of the core.
    logic [LAT:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic [2:0]  out_q [2];
    logic [2:0]  out_d [2];
    logic [2:0]  cnt_q [2];
    logic [2:0]  cnt_d [2];
    logic [1:0]  rd_q [2];
    logic [1:0]  rd_d [2];
    logic [1:0]  wr_q [2];
    logic [1:0]  wr_d [2];
    logic [31:0] mem_q [2][4];
    logic [31:0] mem_d [2][4];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LastPtr) ? 2'd0 : p + 2'd1;
    endfunction

    assign req_valid = {req1_valid, req0_valid};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign res_ready = {res1_ready, res0_ready};

    assign res_valid[0] = (cnt_q[0] != 3'd0);
    assign res_valid[1] = (cnt_q[1] != 3'd0);
    assign pop          = res_valid & res_ready;
    assign push         = tag_v_q[LAT];
    assign push_id      = tag_id_q[LAT];
    assign push_n       = {push & push_id, push & ~push_id};

    // Arbitration, operand capture and tag pipeline next state
    always_comb begin
        elig = 2'b00;
        for (int n = 0; n < 2; n++) begin
            elig[n] = req_valid[n] && (out_q[n] < DepthC);
        end
        grant = elig;
        if (elig == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end
        if (!rst_n) begin
            grant = 2'b00;
        end
        acc    = |grant;
        acc_id = grant[1];
        rr_d   = acc ? ~acc_id : rr_q;
        fpa_a_d = fpa_a_q;
        fpa_b_d = fpa_b_q;
        if (acc) begin
            fpa_a_d = req_a[acc_id];
            fpa_b_d = req_b[acc_id];
        end
        tag_v_d  = {tag_v_q[LAT-1:0], acc};
        tag_id_d = {tag_id_q[LAT-1:0], acc_id};
    end

    // Outstanding credit counters and result FIFO bookkeeping
    always_comb begin
        mem_d = mem_q;
        for (int n = 0; n < 2; n++) begin
            out_d[n] = out_q[n];
            if (grant[n] && !pop[n]) begin
                out_d[n] = out_q[n] + 3'd1;
            end else if (pop[n] && !grant[n]) begin
                out_d[n] = out_q[n] - 3'd1;
            end
            cnt_d[n] = cnt_q[n];
            wr_d[n]  = wr_q[n];
            rd_d[n]  = rd_q[n];
            if (push_n[n]) begin
                mem_d[n][wr_q[n]] = fpa_out;
                wr_d[n]           = ptr_inc(wr_q[n]);
            end
            if (pop[n]) begin
                rd_d[n] = ptr_inc(rd_q[n]);
            end
            if (push_n[n] && !pop[n]) begin
                cnt_d[n] = cnt_q[n] + 3'd1;
            end else if (pop[n] && !push_n[n]) begin
                cnt_d[n] = cnt_q[n] - 3'd1;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= 1'b0;
            fpa_a_q  <= '0;
            fpa_b_q  <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            for (int n = 0; n < 2; n++) begin
                out_q[n] <= '0;
                cnt_q[n] <= '0;
                rd_q[n]  <= '0;
                wr_q[n]  <= '0;
                for (int k = 0; k < 4; k++) begin
                    mem_q[n][k] <= '0;
                end
            end
        end else begin
            rr_q     <= rr_d;
            fpa_a_q  <= fpa_a_d;
            fpa_b_q  <= fpa_b_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            mem_q    <= mem_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign res0_valid = res_valid[0];
    assign res1_valid = res_valid[1];
    assign res0_data  = res_valid[0] ? mem_q[0][rd_q[0]] : 32'd0;
    assign res1_data  = res_valid[1] ? mem_q[1][rd_q[1]] : 32'd0;
    assign fpa_a      = fpa_a_q;
    assign fpa_b      = fpa_b_q;
    // Credits cover both in-flight and buffered results.
    assign busy       = (out_q[0] != 3'd0) || (out_q[1] != 3'd0);

endmodule

// File: tb/tb_fpa_sched.sv
// Scoreboard bench for fpa_sched with a behavioural pipelined core model.
module tb_fpa_sched;

    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 2;

    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res0_valid, res0_ready, res1_valid, res1_ready;
    logic [31:0] res0_data, res1_data;
    logic [31:0] fpa_a, fpa_b, fpa_out;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];

    fpa_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_out(fpa_out), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in core: true IEEE sum for the directed vector, an asymmetric bit mix
    // otherwise so that swapped, stale or misrouted operands are visible.
    function automatic logic [31:0] core_f(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return (a ^ {b[12:0], b[31:13]}) + 32'h9E3779B9;
    endfunction

    logic [31:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= core_f(fpa_a, fpa_b);
        for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign fpa_out = core_pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h7F800000;
            2: return 32'h7FC00000;
            3: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: predicts grants from credits and round-robin, records issued
    // operations, and checks every consumed result against the queue head.
    initial begin
        int n_out0, n_out1;
        logic rr_m, e0, e1;
        logic [1:0] g;
        n_out0 = 0;
        n_out1 = 0;
        rr_m   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp0.delete();
                exp1.delete();
                n_out0 = 0;
                n_out1 = 0;
                rr_m   = 1'b0;
                check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
                check("rst_res_valid", {30'd0, res1_valid, res0_valid}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
            end else begin
                e0 = req0_valid && (n_out0 < DEPTH);
                e1 = req1_valid && (n_out1 < DEPTH);
                g  = (e0 && e1) ? (rr_m ? 2'b10 : 2'b01) : {e1, e0};
                check("ready", {30'd0, req1_ready, req0_ready}, {30'd0, g});
                check("busy", {31'd0, busy}, {31'd0, (n_out0 + n_out1) != 0});
                if (res0_valid) begin
                    if (exp0.size() == 0) check("res0_spurious", 32'd1, 32'd0);
                    else if (res0_ready) begin
                        check("res0_data", res0_data, exp0.pop_front());
                        n_out0--;
                    end
                end
                if (res1_valid) begin
                    if (exp1.size() == 0) check("res1_spurious", 32'd1, 32'd0);
                    else if (res1_ready) begin
                        check("res1_data", res1_data, exp1.pop_front());
                        n_out1--;
                    end
                end
                if (req0_valid && req0_ready) begin
                    exp0.push_back(core_f(req0_a, req0_b));
                    n_out0++;
                    rr_m = 1'b1;
                end
                if (req1_valid && req1_ready) begin
                    exp1.push_back(core_f(req1_a, req1_b));
                    n_out1++;
                    rr_m = 1'b0;
                end
            end
        end
    end

    initial begin
        int lat, acc0, acc1, who, guard;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h11111111; req0_b = 32'h22222222;
        req1_a = 32'h33333333; req1_b = 32'h44444444;
        res0_ready = 1'b1; res1_ready = 1'b1;
        #2;
        check("rst_fpa_a", fpa_a, 32'd0);
        check("rst_fpa_b", fpa_b, 32'd0);
        check("rst_res0_data", res0_data, 32'd0);
        check("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // Single operation: 1.0 + 2.0, latency LAT+1, busy clears after pop
        step();
        req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        check("fpa_a_load", fpa_a, 32'h3F800000);
        lat = 0;
        while (!res0_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, LAT + 1);
        check("sum_1p2", res0_data, 32'h40400000);
        step();
        check("busy_after_pop", {31'd0, busy}, 32'd0);

        // Reset while two operations are in flight
        req0_a = 32'h0BADF00D; req0_b = 32'h12345678; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        req1_a = 32'hCAFEBABE; req1_b = 32'h00C0FFEE; req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        #2 rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h40490FDB; req0_b = 32'h7F800000;
        req1_a = 32'h7FC00000; req1_b = 32'h00000001;
        repeat (3) step();
        check("rst_mid_fpa_a", fpa_a, 32'd0);
        rst_n = 1'b1;

        // Both requesters continuously valid: strict alternation from requester 0
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            who = req0_ready ? 0 : (req1_ready ? 1 : 2);
            check("alternate", who, i % 2);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) step();

        // Requester 0 stalls its results: credits cap accepts at DEPTH
        res0_ready = 1'b0;
        req0_a = 32'h3F000000; req0_b = 32'hBF000000;
        req1_a = 32'h00800000; req1_b = 32'h80000001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        acc0 = 0; acc1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) acc0++;
            if (req1_valid && req1_ready) acc1++;
        end
        check("stall_acc0", acc0, DEPTH);
        check("stall_ready0", {31'd0, req0_ready}, 32'd0);
        check("stall_acc1_min", {31'd0, acc1 >= 3}, 32'd1);
        step();

        // Full FIFO drains while requester 0 keeps offering work
        res0_ready = 1'b1;
        repeat (6) step();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Random traffic with special operand values
        for (int i = 0; i < 1500; i++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = rand_op(); req0_b = rand_op();
            req1_a = rand_op(); req1_b = rand_op();
            res0_ready = ($urandom_range(0, 9) < 7);
            res1_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        res0_ready = 1'b1; res1_ready = 1'b1;
        guard = 0;
        while ((exp0.size() != 0 || exp1.size() != 0 || busy) && guard < 100) begin
            step();
            guard++;
        end
        check("drain_q0", exp0.size(), 0);
        check("drain_q1", exp1.size(), 0);
        check("drain_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
